led_walk_master: RTL and testbench
==================================

# led_walk_master

Avalon-MM initiator that drives the `custom_led` register slave from the other end of its bus. It writes a walking-one pattern to the LED data register, then reads the register back and checks it. It waits a programmable interval and repeats. It sits between the board-level sequencing logic and the LED peripheral, and serves as both a self-test and a demo driver.

## Interface
Parameters:
- `LED_WIDTH`, 10, number of LED bits; the pattern occupies `writedata[LED_WIDTH-1:0]`.
- `INTERVAL`, 50_000_000, idle cycles between the end of one check and the next write (≥1).
- `READ_LATENCY`, 1, cycles from the read-strobe cycle to the cycle in which `readdata` is sampled (≥1).

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run request.
- `clear_error` in 1: synchronous clear of `error` and `error_count`.
- `readdata` in 32: slave read data.
- `address` out 2: slave register address; always `2'b00` (LED data register).
- `chipselect` out 1: slave select.
- `read` out 1: read strobe.
- `write` out 1: write strobe.
- `writedata` out 32: write data, zero-extended pattern.
- `busy` out 1: high in every state except IDLE.
- `pattern` out LED_WIDTH: most recently written pattern.
- `error` out 1: sticky readback-mismatch flag.
- `error_count` out 8: number of mismatches, saturating at 255.

## Operation
- State machine: IDLE, WRITE, READ, CAPTURE, WAIT.
- **IDLE**: all strobes low.
  - `enable`=1 → WRITE.
- **WRITE** (1 cycle): `chipselect`=1, `write`=1, `writedata`={0, next pattern}. `pattern` updates to that value. → READ.
- **READ** (1 cycle): `chipselect`=1, `read`=1, `writedata`=0. → CAPTURE.
- **CAPTURE** (READ_LATENCY cycles): strobes low.
  - On the last cycle, compare `readdata[LED_WIDTH-1:0]` with `pattern`.
  - Upper `readdata` bits are ignored.
  - On mismatch: `error`←1 and `error_count`←min(count+1, 255).
  - → WAIT.
- **WAIT** (INTERVAL cycles): strobes low.
  - If `enable`=0 on any WAIT cycle → IDLE next cycle.
  - Otherwise, at the end of the interval → WRITE.
- Pattern sequence: 1, 2, 4, …, 2^(LED_WIDTH-1), then wraps to 1.
  - The pattern advances only on entry to WRITE.
  - Re-enabling from IDLE continues the sequence; it does not restart at 1.
- `enable` is ignored in WRITE, READ and CAPTURE. A bus transaction is never aborted except by `reset`.
- `clear_error` and a mismatch in the same cycle: the mismatch wins (`error`=1, `error_count`=1).
- `read` and `write` are never high in the same cycle. `chipselect` is high exactly when one of them is high.

## Timing
- All outputs are registered (Moore outputs derived from the state register, plus pattern and error registers).
- Reset values:
  - State: IDLE.
  - `address`=0, `chipselect`=0, `read`=0, `write`=0, `writedata`=0, `busy`=0.
  - `error`=0, `error_count`=0.
  - `pattern`=0; the next pattern is 1.
- `enable` sampled high in IDLE at edge N → `write`=1 during cycle N+1, and `read`=1 during cycle N+2.
- `readdata` is sampled at the edge that ends cycle N+2+READ_LATENCY. With READ_LATENCY=1, the slave registers `readdata` on the edge where `read` is high.
- Steady-state period: 2 + READ_LATENCY + INTERVAL cycles per pattern.
- Each strobe pulse is exactly one clock wide.
- Reset asserted mid-transaction: all strobes drop immediately (asynchronously). There is no partial completion and no error update.

## Structure
- Package `led_walk_pkg`:
  - State enum.
  - Constant `LED_DATA_ADDR` = 2'b00.
  - Constant `ERR_COUNT_MAX` = 8'd255.
- One sub-module, `interval_timer`: a loadable down-counter with a done pulse. It is shared by the CAPTURE (READ_LATENCY) and WAIT (INTERVAL) states and is reloaded on each state entry.
- The top level holds the FSM, the pattern rotate register and the error logic.

## Test plan
Bench parameters: LED_WIDTH=4, INTERVAL=4, READ_LATENCY=1. A behavioural slave model mirrors the `custom_led` register.

1. **Basic cycle.** Reset, then `enable`=1. Required: one-cycle writes with `writedata` 1, 2, 4, 8, then 1 again (wrap); each write is followed by a one-cycle read; `write` pulses are 7 cycles apart; `error` stays 0.
2. **Readback mismatch.** The slave model forces `readdata`=0 on the second read. Required: `error`=1 and `error_count`=1; later matching reads leave both unchanged.
3. **Stop and resume.** Drop `enable` during READ of pattern 2. Required: CAPTURE and WAIT-entry complete, then IDLE with `busy`=0. Re-enable: the next write is 4.
4. **Clear collision.** Assert `clear_error` in the same cycle as a mismatch compare with `error_count`=3. Required: `error_count`=1, `error`=1.
5. **Reset mid-write.** Assert `reset` asynchronously during the WRITE cycle. Required: `write` and `chipselect` drop without waiting for a clock edge; after release the first write is 1.
6. **Saturation.** With `readdata` stuck at 0, run 300 patterns. Required: `error_count` holds at 255 and never wraps.

Source files
------------

// File: rtl/led_walk_pkg.sv
// rtl/led_walk_pkg.sv - shared types and constants for the LED walk initiator
package led_walk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_WAIT    = 3'd4
  } state_e;

  localparam logic [1:0] LED_DATA_ADDR = 2'b00;
  localparam logic [7:0] ERR_COUNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/led_walk_master_if.sv
// rtl/led_walk_master_if.sv - Avalon-MM bus between the LED walk initiator and the LED slave
interface led_walk_master_if;
  import led_walk_pkg::*;

  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/led_walk_master_interval_timer.sv
// rtl/led_walk_master_interval_timer.sv - loadable down-counter, done on the last counted cycle
module interval_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  // Loaded with value-1 so that done is high during the value'th cycle after the load edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value - WIDTH'(1);
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/led_walk_master.sv
// rtl/led_walk_master.sv - walking-one LED writer with readback check and error tally
module led_walk_master
  import led_walk_pkg::*;
#(
  parameter int LED_WIDTH    = 10,
  parameter int INTERVAL     = 50_000_000,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear_error,
  led_walk_master_if.master    bus,
  output logic                 busy,
  output logic [LED_WIDTH-1:0] pattern,
  output logic                 error,
  output logic [7:0]           error_count
);

  state_e               r_state;
  logic [LED_WIDTH-1:0] r_pattern;
  logic                 r_error;
  logic [7:0]           r_error_count;

  logic                 w_done;
  logic                 w_load;
  logic [31:0]          w_load_value;
  logic [LED_WIDTH-1:0] w_next_pattern;
  logic                 w_compare;
  logic                 w_mismatch;
  logic                 w_unused_rd;

  // Pattern register starts at 0 so the first write after reset is 1.
  assign w_next_pattern = (r_pattern == '0 || r_pattern[LED_WIDTH-1])
                        ? LED_WIDTH'(1) : (r_pattern << 1);

  assign w_load       = (r_state == ST_READ) || (r_state == ST_CAPTURE && w_done);
  assign w_load_value = (r_state == ST_READ) ? 32'(READ_LATENCY) : 32'(INTERVAL);

  interval_timer #(.WIDTH(32)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_load_value),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state   <= ST_WRITE;
            r_pattern <= w_next_pattern;
          end
        end
        ST_WRITE:   r_state <= ST_READ;
        ST_READ:    r_state <= ST_CAPTURE;
        ST_CAPTURE: if (w_done) r_state <= ST_WAIT;
        ST_WAIT: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (w_done) begin
            r_state   <= ST_WRITE;
            r_pattern <= w_next_pattern;
          end
        end
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_compare   = (r_state == ST_CAPTURE) && w_done;
  assign w_mismatch  = w_compare && (bus.readdata[LED_WIDTH-1:0] != r_pattern);
  assign w_unused_rd = ^bus.readdata[31:LED_WIDTH];

  // A mismatch in the same cycle as clear_error wins: the tally restarts at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_error       <= 1'b0;
      r_error_count <= 8'd0;
    end else if (w_mismatch) begin
      r_error       <= 1'b1;
      r_error_count <= clear_error ? 8'd1 : sat_inc(r_error_count);
    end else if (clear_error) begin
      r_error       <= 1'b0;
      r_error_count <= 8'd0;
    end
  end

  // Strobes decode straight from the state register so reset drops them asynchronously.
  assign bus.address    = LED_DATA_ADDR;
  assign bus.write      = (r_state == ST_WRITE);
  assign bus.read       = (r_state == ST_READ);
  assign bus.chipselect = bus.write || bus.read;
  assign bus.writedata  = bus.write ? 32'(r_pattern) : 32'd0;

  assign busy        = (r_state != ST_IDLE);
  assign pattern     = r_pattern;
  assign error       = r_error;
  assign error_count = r_error_count;

endmodule

// File: tb/tb_led_walk_master.sv
// tb/tb_led_walk_master.sv - self-checking bench for led_walk_master
module tb_led_walk_master;

  localparam int LW = 4;
  localparam int IV = 4;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          clear_error = 1'b0;
  logic          busy;
  logic [LW-1:0] pattern;
  logic          error;
  logic [7:0]    error_count;

  led_walk_master_if bus();

  led_walk_master #(.LED_WIDTH(LW), .INTERVAL(IV), .READ_LATENCY(RL)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear_error (clear_error),
    .bus         (bus),
    .busy        (busy),
    .pattern     (pattern),
    .error       (error),
    .error_count (error_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: custom_led data register; rd_mode 0 = echo (random upper bits), 1 = zero, 2 = corrupt low bits.
  int          rd_mode = 0;
  logic [LW-1:0] led_reg;

  function automatic logic [31:0] mk_rd(input int mode, input logic [LW-1:0] v);
    logic [31:0] r;
    logic [3:0]  f;
    r = $urandom();
    f = 4'($urandom_range(1, 15));
    case (mode)
      0:       return {r[31:LW], v};
      1:       return 32'd0;
      default: return {r[31:LW], v ^ f};
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg      <= '0;
      bus.readdata <= '0;
    end else begin
      if (bus.chipselect && bus.write) led_reg <= bus.writedata[LW-1:0];
      if (bus.chipselect && bus.read)  bus.readdata <= mk_rd(rd_mode, led_reg);
    end
  end

  // Reference model: k-th write since reset is 1 << (k mod LW); mismatches tally with saturation.
  int exp_idx = 0;
  int exp_cnt = 0;
  bit exp_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    clear_error = 1'b0;
    rd_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bus", {bus.address, bus.chipselect, bus.read, bus.write, bus.writedata, busy}, 64'd0);
    chk("reset_regs", {pattern, error, error_count}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_idx = 0;
    exp_cnt = 0;
    exp_err = 0;
    step();
  endtask

  task automatic wait_write(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.write) begin
        ok = 1;
        return;
      end
      step();
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_write: no write strobe within 40 cycles (cycle %0d)", cyc);
  endtask

  task automatic do_pattern(input int mode, input bit clr, output int wcyc);
    bit          ok;
    logic [31:0] ew;
    wait_write(ok);
    wcyc = cyc;
    if (!ok) return;
    ew = 32'd1 << (exp_idx % LW);
    chk("writedata", bus.writedata, ew);
    chk("pattern", pattern, ew);
    chk("write_cs", {bus.chipselect, bus.read}, 2'b10);
    rd_mode = mode;
    exp_idx++;
    step();
    chk("read_strobe", {bus.chipselect, bus.read, bus.write, bus.writedata}, {3'b110, 32'd0});
    step();
    chk("capture_quiet", {bus.chipselect, bus.read, bus.write}, 3'b000);
    clear_error = clr;
    step();
    clear_error = 1'b0;
    if (mode != 0) begin
      exp_err = 1;
      exp_cnt = clr ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
    end else if (clr) begin
      exp_err = 0;
      exp_cnt = 0;
    end
    chk("error", error, exp_err);
    chk("error_count", error_count, exp_cnt);
  endtask

  typedef struct {
    logic          en;
    logic          cs;
    logic          rd;
    logic          wr;
    logic          bsy;
    logic [31:0]   wd;
    logic [LW-1:0] pat;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int wc;
    int prev;
    bit ok;

    // Cycle table: two patterns, enable dropped during READ of pattern 2, then resume.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd1, 4'd1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 4'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 4'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 4'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 4'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 4'd1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 4'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 4'd2};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 4'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 4'd2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 4'd2};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd2};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd2};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd4, 4'd4};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      enable = tbl[i].en;
      step();
      chk($sformatf("vec%0d_bus", i),
          {bus.chipselect, bus.read, bus.write, busy, bus.writedata},
          {tbl[i].cs, tbl[i].rd, tbl[i].wr, tbl[i].bsy, tbl[i].wd});
      chk($sformatf("vec%0d_pattern", i), pattern, tbl[i].pat);
    end
    chk("vec_error", {error, error_count}, 9'd0);

    // Basic cycle with wrap and write spacing.
    do_reset();
    enable = 1'b1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      do_pattern(0, 0, wc);
      if (k > 0) chk("write_spacing", wc - prev, 2 + RL + IV);
      prev = wc;
    end

    // Readback mismatch on the second read.
    do_reset();
    enable = 1'b1;
    do_pattern(0, 0, wc);
    do_pattern(1, 0, wc);
    do_pattern(0, 0, wc);
    do_pattern(0, 0, wc);
    chk("mismatch_sticky", {error, error_count}, {1'b1, 8'd1});

    // Clear colliding with a mismatch at count 3.
    do_reset();
    enable = 1'b1;
    repeat (3) do_pattern(1, 0, wc);
    do_pattern(1, 1, wc);
    chk("clear_collision", {error, error_count}, {1'b1, 8'd1});
    do_pattern(0, 1, wc);

    // Asynchronous reset in the middle of a WRITE cycle.
    do_reset();
    enable = 1'b1;
    wait_write(ok);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_strobes", {bus.write, bus.chipselect, busy}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    exp_idx = 0;
    exp_cnt = 0;
    exp_err = 0;
    step();
    do_pattern(0, 0, wc);

    // Randomized patterns against the reference model.
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 60; k++)
      do_pattern(int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0), wc);

    // Saturation with readdata stuck at zero.
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 300; k++) do_pattern(1, 0, wc);
    chk("saturation", error_count, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
